// File: rtl/eh2_lsu_ecc_scrub_if.sv
// Correction writeback port between the ECC scrubber and the DCCM write arbiter.
//
// Handshake: wb_valid/wb_ready. A transfer happens on a rising clk edge where
// wb_valid & wb_ready are both high. While wb_valid is high and wb_ready is low,
// wb_bank/wb_addr/wb_data/wb_ecc hold steady. The one exception is a store to
// the head entry's bank/address: the request is then withdrawn (wb_valid drops
// without a transfer), because the store has already overwritten the bad word.
// wb_ready may depend combinationally on wb_valid; wb_valid never depends on wb_ready.
interface eh2_lsu_ecc_scrub_if #(
  parameter int BANK_W     = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [BANK_W-1:0]     wb_bank;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [ECC_WIDTH-1:0]  wb_ecc;

  // Scrubber side: issues correction writebacks.
  modport master (
    output wb_valid, wb_bank, wb_addr, wb_data, wb_ecc,
    input  wb_ready
  );

  // Arbiter side: accepts correction writebacks.
  modport slave (
    input  wb_valid, wb_bank, wb_addr, wb_data, wb_ecc,
    output wb_ready
  );
endinterface

// File: rtl/eh2_lsu_ecc_scrub.sv
// Multi-bank DCCM SEC-DED check-and-repair. Each bank readout is decoded with
// zero latency; single-bit errors are queued (deduplicated, store-killed,
// compacted) and written back through the wb interface. Saturating SEC/DED
// counters drive a sticky threshold interrupt.
module eh2_lsu_ecc_scrub #(
  parameter int  NUM_BANKS  = 2,
  parameter int  DATA_WIDTH = 32,
  parameter int  ECC_WIDTH  = 7,
  parameter int  ADDR_WIDTH = 16,
  parameter int  FIFO_DEPTH = 4,
  parameter int  CNT_WIDTH  = 16,
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            ecc_disable,
  input  logic [NUM_BANKS-1:0]            rd_valid,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
  input  logic [NUM_BANKS*ECC_WIDTH-1:0]  rd_ecc,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data_corr,
  output logic [NUM_BANKS-1:0]            rd_sec,
  output logic [NUM_BANKS-1:0]            rd_ded,
  input  logic                            st_valid,
  input  logic [BANK_W-1:0]               st_bank,
  input  logic [ADDR_WIDTH-1:0]           st_addr,
  eh2_lsu_ecc_scrub_if.master             wb,
  output logic [CNT_WIDTH-1:0]            sec_count,
  output logic [CNT_WIDTH-1:0]            ded_count,
  input  logic [CNT_WIDTH-1:0]            sec_thresh,
  output logic                            err_irq,
  output logic                            fifo_ovf,
  input  logic                            err_clr
);

  localparam int SYN_W = ECC_WIDTH - 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Codeword position of every data bit: data fills the non-power-of-two
  // positions from 3 upward; check bit i covers positions with bit i set.
  function automatic logic [DATA_WIDTH*SYN_W-1:0] pos_table();
    logic [DATA_WIDTH*SYN_W-1:0] tbl;
    int n;
    tbl = '0;
    n = 0;
    for (int p = 3; p < (1 << SYN_W); p++) begin
      if (((p & (p - 1)) != 0) && (n < DATA_WIDTH)) begin
        tbl[n*SYN_W +: SYN_W] = SYN_W'(p);
        n++;
      end
    end
    return tbl;
  endfunction

  localparam logic [DATA_WIDTH*SYN_W-1:0] POS_TBL = pos_table();

  // Hamming check bits plus overall parity in the top bit.
  function automatic logic [ECC_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
    logic [ECC_WIDTH-1:0] e;
    e = '0;
    for (int i = 0; i < SYN_W; i++) begin
      for (int j = 0; j < DATA_WIDTH; j++) begin
        if (POS_TBL[j*SYN_W + i]) e[i] = e[i] ^ d[j];
      end
    end
    e[ECC_WIDTH-1] = ^{d, e[SYN_W-1:0]};
    return e;
  endfunction

  // {overall parity mismatch, syndrome}.
  function automatic logic [ECC_WIDTH-1:0] ecc_check(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [ECC_WIDTH-1:0]  e);
    logic [ECC_WIDTH-1:0] calc;
    calc = ecc_encode(d);
    return {^{d, e}, e[SYN_W-1:0] ^ calc[SYN_W-1:0]};
  endfunction

  // Flip the data bit whose codeword position equals the syndrome; a syndrome
  // pointing at a check bit (or zero) leaves the data untouched.
  function automatic logic [DATA_WIDTH-1:0] ecc_correct(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [SYN_W-1:0]      syn);
    logic [DATA_WIDTH-1:0] c;
    c = d;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if (POS_TBL[j*SYN_W +: SYN_W] == syn) c[j] = ~d[j];
    end
    return c;
  endfunction

  // Queue storage: slot 0 is always the head, valid slots are contiguous.
  logic [BANK_W-1:0]     bank_q [FIFO_DEPTH];
  logic [BANK_W-1:0]     bank_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;

  logic [CNT_WIDTH-1:0]  sec_count_q, sec_count_d;
  logic [CNT_WIDTH-1:0]  ded_count_q, ded_count_d;
  logic                  err_irq_q, err_irq_d;
  logic                  fifo_ovf_q, fifo_ovf_d;

  logic [ECC_WIDTH-1:0]  chk_v [NUM_BANKS];
  logic [NUM_BANKS-1:0]  sec_v, ded_v;
  logic                  pop, ovf_set, dup, killed;
  int                    occ, avail, wr, npush;
  logic [CNT_WIDTH:0]    sec_sum, ded_sum;
  logic [CNT_WIDTH-1:0]  sec_upd;
  int                    sec_pc, ded_pc;

  // Per-bank zero-latency decode and correction.
  always_comb begin
    rd_data_corr = '0;
    sec_v        = '0;
    ded_v        = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      chk_v[b] = ecc_check(rd_data[b*DATA_WIDTH +: DATA_WIDTH], rd_ecc[b*ECC_WIDTH +: ECC_WIDTH]);
      sec_v[b] = rd_valid[b] & ~ecc_disable & chk_v[b][ECC_WIDTH-1];
      ded_v[b] = rd_valid[b] & ~ecc_disable & ~chk_v[b][ECC_WIDTH-1] &
                 (chk_v[b][SYN_W-1:0] != '0);
      rd_data_corr[b*DATA_WIDTH +: DATA_WIDTH] =
        (~ecc_disable & chk_v[b][ECC_WIDTH-1]) ?
          ecc_correct(rd_data[b*DATA_WIDTH +: DATA_WIDTH], chk_v[b][SYN_W-1:0]) :
          rd_data[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rd_sec = sec_v;
  assign rd_ded = ded_v;

  // Queue update: drop popped/killed entries, compact, then append new SECs in bank order.
  always_comb begin
    bank_d  = bank_q;
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = '0;
    ovf_set = 1'b0;
    dup     = 1'b0;
    killed  = 1'b0;
    pop     = vld_q[0] & wb.wb_ready;
    occ     = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) occ = occ + int'(vld_q[i]);
    // Kills do not add space this cycle; only a pop does.
    avail   = FIFO_DEPTH - occ + int'(pop);
    wr      = 0;
    npush   = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[i] && !(i == 0 && pop) &&
          !(st_valid && bank_q[i] == st_bank && addr_q[i] == st_addr)) begin
        bank_d[wr[PTR_W-1:0]] = bank_q[i];
        addr_d[wr[PTR_W-1:0]] = addr_q[i];
        data_d[wr[PTR_W-1:0]] = data_q[i];
        vld_d[wr[PTR_W-1:0]]  = 1'b1;
        wr = wr + 1;
      end
    end
    // Same-cycle pushes come from distinct banks, so only queued entries can duplicate.
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (sec_v[b]) begin
        dup = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (vld_q[i] && bank_q[i] == BANK_W'(b) &&
              addr_q[i] == rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH]) dup = 1'b1;
        end
        killed = st_valid && (st_bank == BANK_W'(b)) &&
                 (st_addr == rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH]);
        if (!dup && !killed) begin
          if (npush < avail) begin
            bank_d[wr[PTR_W-1:0]] = BANK_W'(b);
            addr_d[wr[PTR_W-1:0]] = rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
            data_d[wr[PTR_W-1:0]] = rd_data_corr[b*DATA_WIDTH +: DATA_WIDTH];
            vld_d[wr[PTR_W-1:0]]  = 1'b1;
            wr    = wr + 1;
            npush = npush + 1;
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
    end
  end

  // Saturating counters, sticky interrupt and overflow; err_clr wins.
  always_comb begin
    sec_pc = 0;
    ded_pc = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      sec_pc = sec_pc + int'(sec_v[b]);
      ded_pc = ded_pc + int'(ded_v[b]);
    end
    sec_sum     = {1'b0, sec_count_q} + (CNT_WIDTH+1)'(sec_pc);
    ded_sum     = {1'b0, ded_count_q} + (CNT_WIDTH+1)'(ded_pc);
    sec_upd     = sec_sum[CNT_WIDTH] ? '1 : sec_sum[CNT_WIDTH-1:0];
    sec_count_d = err_clr ? '0 : sec_upd;
    ded_count_d = err_clr ? '0 : (ded_sum[CNT_WIDTH] ? '1 : ded_sum[CNT_WIDTH-1:0]);
    err_irq_d   = err_clr ? 1'b0 :
                  (err_irq_q | ((sec_thresh != '0) && (sec_upd >= sec_thresh)));
    fifo_ovf_d  = err_clr ? 1'b0 : (fifo_ovf_q | ovf_set);
  end

  // State registers; reset discards the queue asynchronously.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        bank_q[i] <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q       <= '0;
      sec_count_q <= '0;
      ded_count_q <= '0;
      err_irq_q   <= 1'b0;
      fifo_ovf_q  <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      sec_count_q <= sec_count_d;
      ded_count_q <= ded_count_d;
      err_irq_q   <= err_irq_d;
      fifo_ovf_q  <= fifo_ovf_d;
    end
  end

  assign wb.wb_valid = vld_q[0];
  assign wb.wb_bank  = bank_q[0];
  assign wb.wb_addr  = addr_q[0];
  assign wb.wb_data  = data_q[0];
  assign wb.wb_ecc   = ecc_encode(data_q[0]);

  assign sec_count = sec_count_q;
  assign ded_count = ded_count_q;
  assign err_irq   = err_irq_q;
  assign fifo_ovf  = fifo_ovf_q;

endmodule

// File: doc/eh2_lsu_ecc_scrub.md
Name: eh2_lsu_ecc_scrub

Overview:
Parametrised multi-bank DCCM ECC check-and-repair block for the LSU, sitting between the DCCM read ports and the DCCM write arbiter. Each bank's readout gets a SEC-DED decode. Single-bit errors are queued in a correction FIFO and written back through a valid/ready port to the arbiter. Per-type error counters and a threshold interrupt feed the TLU.

Parameters:
NUM_BANKS, 2, number of DCCM banks checked in parallel (1..8)
DATA_WIDTH, 32, data bits per bank word
ECC_WIDTH, 7, check bits per word; must satisfy 2^(ECC_WIDTH-1) >= DATA_WIDTH+ECC_WIDTH
ADDR_WIDTH, 16, bank word-address width
FIFO_DEPTH, 4, correction queue entries (power of 2, >=2)
CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  core clock
rst_l  in  1  reset; asynchronous, active-low
ecc_disable  in  1  suppresses detection, queueing and counting
rd_valid  in  NUM_BANKS  per-bank read data valid this cycle
rd_addr  in  NUM_BANKS*ADDR_WIDTH  per-bank word address
rd_data  in  NUM_BANKS*DATA_WIDTH  raw data from memory
rd_ecc  in  NUM_BANKS*ECC_WIDTH  stored check bits
rd_data_corr  out  NUM_BANKS*DATA_WIDTH  corrected data (combinational)
rd_sec  out  NUM_BANKS  single error detected and corrected
rd_ded  out  NUM_BANKS  double error detected
st_valid  in  1  store write to DCCM this cycle
st_bank  in  $clog2(NUM_BANKS) (min 1)  bank of the store
st_addr  in  ADDR_WIDTH  word address of the store
wb_valid  out  1  correction writeback request
wb_ready  in  1  arbiter accepts the request
wb_bank  out  $clog2(NUM_BANKS) (min 1)  writeback bank
wb_addr  out  ADDR_WIDTH  writeback address
wb_data  out  DATA_WIDTH  corrected data
wb_ecc  out  ECC_WIDTH  check bits freshly encoded from wb_data
sec_count  out  CNT_WIDTH  saturating SEC event count
ded_count  out  CNT_WIDTH  saturating DED event count
sec_thresh  in  CNT_WIDTH  interrupt threshold; 0 disables
err_irq  out  1  sticky threshold interrupt
fifo_ovf  out  1  sticky: a correction was dropped
err_clr  in  1  clears counters, err_irq and fifo_ovf

Behaviour:
- Reset values: FIFO empty, wb_valid=0, wb_bank/addr/data/ecc=0, sec_count=0, ded_count=0, err_irq=0, fifo_ovf=0.
- Decode: Hamming SEC-DED, same code as rvecc_encode/rvecc_decode, zero latency. rd_sec and rd_ded are gated by rd_valid & ~ecc_disable.
- When ecc_disable=1: rd_data_corr equals rd_data, and no push and no count occurs. The FIFO keeps draining.
- Push:
  - In cycle N, each bank with rd_sec pushes {bank, addr, corrected data}.
  - Banks are pushed in ascending index order.
  - Space available = FIFO_DEPTH - occupancy + (pop in cycle N).
  - Requests beyond the available space are dropped and set fifo_ovf.
  - A pushed entry is visible on wb_* in cycle N+1 at the earliest.
- Duplicate suppression: no push occurs if a valid entry with the same bank and address exists. This covers entries already in the FIFO and entries pushed earlier in the same cycle.
- Pop:
  - wb_valid = head entry valid.
  - The head is removed on wb_valid & wb_ready.
  - While wb_valid & ~wb_ready, wb_* stay stable, except when the head is killed by a store.
- Store kill: with st_valid, every entry matching st_bank/st_addr is invalidated in the same cycle. This includes the head, so wb_valid may drop without a handshake. Killed slots are compacted, so the FIFO never presents an invalid entry.
- Same-cycle ordering: a kill applies before pushes, so a same-cycle SEC push to the stored address is also suppressed.
- Counters:
  - sec_count increments by the popcount of rd_sec; ded_count increments by the popcount of rd_ded.
  - Both saturate at all-ones with no wrap.
  - Dropped and duplicate SECs are still counted.
- err_irq: set in cycle N+1 when sec_thresh!=0 and the updated sec_count >= sec_thresh. It stays set until err_clr.
- err_clr: zeros sec_count, ded_count, err_irq and fifo_ovf next cycle. It wins over a same-cycle increment or set. FIFO contents are unaffected.
- rst_l asserted mid-transfer: the FIFO is discarded immediately and wb_valid falls asynchronously.

Test Plan:
- Bank0 data 0x12345678 with bit 5 flipped, rd_valid=01 -> rd_data_corr[0]=0x12345678, rd_sec=01; next cycle wb_valid=1, wb_addr matches, wb_ecc=encode(0x12345678), sec_count=1.
- Two-bit flip on bank1 -> rd_ded=10, no push, ded_count=1, wb_valid stays 0.
- FIFO_DEPTH=4, wb_ready=0, six distinct SECs -> four entries held, fifo_ovf=1, sec_count=6; then wb_ready=1 -> four pops in FIFO order.
- SEC at bank0 addr 0x40 queued, wb_ready=0, st_valid to bank0 addr 0x40 -> wb_valid=0 next cycle, entry gone; repeated SEC at same addr while queued -> single entry only.
- sec_thresh=3, three SECs -> err_irq=1 after the third; err_clr same cycle as a fourth SEC -> counts=0, err_irq=0.
- ecc_disable=1 with a single-bit flip -> rd_data_corr equals raw data, no push, counters unchanged.
